// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit, request-to-send, then shift 8 data bits, odd parity and stop, and check the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC  = 953,
  parameter int unsigned RTS_CYC      = 10,
  parameter int unsigned START_TO_CYC = 142860,
  parameter int unsigned PKT_TO_CYC   = 19048
) (
  input  logic       clk_kb,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  localparam logic [17:0] INHIBIT_LAST = 18'(INHIBIT_CYC - 1);
  localparam logic [17:0] RTS_LAST     = 18'(RTS_CYC - 1);
  localparam logic [17:0] START_TO     = 18'(START_TO_CYC);
  // Counter restarts on the cycle of edge 1, so it lags that edge by one.
  localparam logic [17:0] PKT_LAST     = 18'(PKT_TO_CYC - 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_PKT   = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  frame_q, frame_d;
  logic        dat_oe_q, dat_oe_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        fall;

  assign fall       = clk_prev & ~clk_s2;
  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rx_inhibit = busy;
  assign err_code   = error ? err_code_d : err_code_q;

  always_ff @(posedge clk_kb or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      dat_oe_q   <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      clk_s1     <= ps2_clk_i;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= ps2_dat_i;
      dat_s2     <= dat_s1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      dat_oe_q   <= dat_oe_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 18'd1;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    dat_oe_d   = dat_oe_q;
    err_code_d = err_code_q;
    done       = 1'b0;
    error      = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_d    = {1'b1, ~^tx_data, tx_data};
          err_code_d = ERR_NONE;
          cnt_d      = '0;
          state_d    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q >= INHIBIT_LAST) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end
      end

      S_RTS: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        if (cnt_q >= RTS_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          dat_oe_d  = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        ps2_dat_oe = dat_oe_q;
        // A detected edge always wins over a timeout expiring in the same cycle.
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            cnt_d = '0;
          end
          if (bit_cnt_q == 4'd10) begin
            if (!dat_s2) begin
              dat_oe_d = 1'b0;
              state_d  = S_WAIT_IDLE;
            end else begin
              error      = 1'b1;
              err_code_d = ERR_NOACK;
            end
          end else begin
            dat_oe_d = ~frame_q[0];
            frame_d  = {1'b1, frame_q[9:1]};
          end
        end else if (bit_cnt_q == 4'd0 && cnt_q >= START_TO) begin
          error      = 1'b1;
          err_code_d = ERR_START;
        end else if (bit_cnt_q != 4'd0 && cnt_q >= PKT_LAST) begin
          error      = 1'b1;
          err_code_d = ERR_PKT;
        end
        if (error) begin
          ps2_dat_oe = 1'b0;
          dat_oe_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 953, is the CLK-low inhibit time in clock cycles (≥100 us at 9.524 MHz).
REQ-002 Parameter RTS_CYC, default 10, is the cycles with both lines low before CLK is released.
REQ-003 Parameter START_TO_CYC, default 142860, is the cycles allowed from CLK release to the first device falling edge (15 ms).
REQ-004 Parameter PKT_TO_CYC, default 19048, is the cycles allowed from the first falling edge to the ACK edge (2 ms).
REQ-005 Port clk_kb, input, 1 bit: the single clock; all logic is rising-edge on clk_kb.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port tx_data, input, 8 bits: command byte to send.
REQ-008 Port tx_valid, input, 1 bit: send request.
REQ-009 Port tx_ready, output, 1 bit: high only in IDLE.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port done, output, 1 bit: one-cycle pulse on successful, acknowledged completion.
REQ-012 Port error, output, 1 bit: one-cycle pulse on failed completion.
REQ-013 Port err_code, output, 2 bits: 00 none, 01 start timeout, 10 packet timeout, 11 no ACK; held until the next accept.
REQ-014 Port rx_inhibit, output, 1 bit: equals busy, so the PS/2 receiver ignores the bus during host transmit.
REQ-015 Ports ps2_clk_i and ps2_dat_i, inputs, 1 bit each: raw open-drain line levels.
REQ-016 Ports ps2_clk_oe and ps2_dat_oe, outputs, 1 bit each: 1 pulls the line low, 0 releases it.

Function
REQ-017 ps2_clk_i and ps2_dat_i SHALL each pass a 2-FF synchronizer; a falling edge SHALL be detected as sync-prev=1 and sync-now=0.
REQ-018 The block accepts a request when tx_valid=1 and tx_ready=1 on a clock edge: it latches tx_data, computes parity = ~^tx_data (odd parity), clears err_code, and enters INHIBIT.
REQ-019 tx_valid SHALL be ignored while busy=1.
REQ-020 INHIBIT: clk_oe=1 and dat_oe=0 for exactly INHIBIT_CYC cycles, then go to RTS.
REQ-021 RTS: clk_oe=1 and dat_oe=1 (start bit 0) for RTS_CYC cycles, then go to SHIFT with clk_oe=0 and dat_oe still 1.
REQ-022 SHIFT (bit counter 0..10, reset to 0 on entry), action on each detected CLK falling edge:
- edges 1-8: drive data bit n-1, LSB first (dat_oe = ~bit);
- edge 9: drive parity;
- edge 10: release data (stop bit, dat_oe=0);
- edge 11: sample synced DAT; 0 means ACK, go to WAIT_IDLE; 1 means error 11.
REQ-023 Data SHALL change only in the cycle after a falling edge is detected, never on rising edges.
REQ-024 WAIT_IDLE: both oe=0; when synced CLK=1 and DAT=1, pulse done and go to IDLE.
REQ-025 Start timeout: if no falling edge arrives within START_TO_CYC cycles of entering SHIFT, raise error with code 01.
REQ-026 Packet timeout: if edge 11 has not arrived within PKT_TO_CYC cycles of edge 1, raise error with code 10.
REQ-027 On any error: both oe=0 in the same cycle error pulses, then IDLE next cycle; done SHALL NOT pulse.
REQ-028 If a timeout expiry and a falling edge coincide, the edge takes priority.
REQ-029 Falling edges seen in IDLE, INHIBIT or RTS SHALL be ignored.
REQ-030 The timeout counter SHALL be 18 bits, saturating, and cleared on entry to each timed phase.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, clk_oe=0, dat_oe=0, tx_ready=1, busy=0, rx_inhibit=0, done=0, error=0, err_code=00, synchronizers=1.
REQ-032 A reset mid-packet SHALL release both lines immediately, with no done or error pulse.

Verification
REQ-033 Send tx_data=0xED with a device model that ACKs -> bits sampled 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; err_code=00.
REQ-034 Send tx_data=0x01 -> parity bit 0; CLK held low ≥953 cycles; DAT low ≥10 cycles before CLK release.
REQ-035 Device never clocks -> exactly 142860 cycles after CLK release, error pulses with err_code=01 and both oe=0.
REQ-036 Device leaves DAT high at edge 11 -> error with err_code=11; next request accepted normally.
REQ-037 Assert rst_n=0 after edge 4 -> both oe=0 asynchronously; tx_ready=1 after release; no done or error pulse.
REQ-038 tx_valid pulsed with 0x55 while busy sending 0xF4 -> only 0xF4 appears on the bus; one done pulse.
